// File: rtl/ptcalc_div_pkg.sv
// Shared widths, saturation limits and FSM encoding for the pT-calc
// signed-by-unsigned divider.
package ptcalc_div_pkg;

    localparam int DIVIDEND_W = 29;
    localparam int DIVISOR_W  = 7;
    localparam int QUOT_W     = 22;
    localparam int CNT_W      = $clog2(DIVIDEND_W);

    localparam logic signed [QUOT_W-1:0] QMAX = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic signed [QUOT_W-1:0] QMIN = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/ptcalc_div_step.sv
// One combinational radix-2 restoring step: shift in the next dividend bit,
// subtract the divisor when it fits.
module ptcalc_div_step
    import ptcalc_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   pr_in,
    input  logic                 nbit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_out,
    output logic                 qbit
);

    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W:0]   diff;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        shifted = {pr_in, nbit};
        diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
        qbit    = (shifted >= {2'b00, divisor});
        pr_out  = qbit ? diff : shifted[DIVISOR_W:0];
    end

endmodule

// File: rtl/ptcalc_top_sdiv_u7.sv
// Sequential s29 / u7 divider, one quotient bit per cycle, with saturation
// of the quotient to s22 and C-style remainder sign.
module ptcalc_top_sdiv_u7
    import ptcalc_div_pkg::*;
(
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic signed [DIVIDEND_W-1:0] din0,
    input  logic        [DIVISOR_W-1:0]  din1,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic signed [QUOT_W-1:0]     dout,
    output logic signed [DIVISOR_W:0]    rem,
    output logic                        div0,
    output logic                        ovf
);

    localparam logic [DIVIDEND_W-1:0] QMAG_POS = DIVIDEND_W'(QMAX);
    localparam logic [DIVIDEND_W-1:0] QMAG_NEG = DIVIDEND_W'(1) << (QUOT_W-1);

    state_t                 state;
    logic                   neg;
    logic                   zero_div;
    logic [DIVIDEND_W-1:0]  dq;       // dividend bits leave at the MSB, quotient bits enter at the LSB
    logic [DIVISOR_W-1:0]   divisor;
    logic [DIVISOR_W:0]     pr;
    logic [CNT_W-1:0]       cnt;

    logic [DIVISOR_W:0]        pr_next;
    logic                      qbit;
    logic signed [QUOT_W-1:0]  q_fix;
    logic signed [DIVISOR_W:0] rem_fix;
    logic                      ovf_fix;

    ptcalc_div_step u_step (
        .pr_in   (pr),
        .nbit    (dq[DIVIDEND_W-1]),
        .divisor (divisor),
        .pr_out  (pr_next),
        .qbit    (qbit)
    );

    // Sign fix-up and saturation operate on the unsigned magnitude.
    always_comb begin
        q_fix   = dq[QUOT_W-1:0];
        ovf_fix = 1'b0;
        if (neg) begin
            q_fix = -dq[QUOT_W-1:0];
            if (dq > QMAG_NEG) begin
                q_fix   = QMIN;
                ovf_fix = 1'b1;
            end
        end else if (dq > QMAG_POS) begin
            q_fix   = QMAX;
            ovf_fix = 1'b1;
        end
        rem_fix = neg ? -pr : pr;
    end

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state    <= S_IDLE;
            in_rdy   <= 1'b1;
            out_vld  <= 1'b0;
            dout     <= '0;
            rem      <= '0;
            div0     <= 1'b0;
            ovf      <= 1'b0;
            neg      <= 1'b0;
            zero_div <= 1'b0;
            dq       <= '0;
            divisor  <= '0;
            pr       <= '0;
            cnt      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_vld && in_rdy) begin
                        neg      <= din0[DIVIDEND_W-1];
                        dq       <= din0[DIVIDEND_W-1] ? -din0 : din0;
                        divisor  <= din1;
                        zero_div <= (din1 == '0);
                        pr       <= '0;
                        cnt      <= '0;
                        in_rdy   <= 1'b0;
                        state    <= (din1 == '0) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    pr  <= pr_next;
                    dq  <= {dq[DIVIDEND_W-2:0], qbit};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DIVIDEND_W-1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (zero_div) begin
                        dout <= neg ? QMIN : QMAX;
                        rem  <= '0;
                        div0 <= 1'b1;
                        ovf  <= 1'b0;
                    end else begin
                        dout <= q_fix;
                        rem  <= rem_fix;
                        div0 <= 1'b0;
                        ovf  <= ovf_fix;
                    end
                    out_vld <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    if (out_rdy) begin
                        out_vld <= 1'b0;
                        in_rdy  <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ptcalc_top_sdiv_u7.sv
// Directed and random-round-trip bench for ptcalc_top_sdiv_u7; expected results
// come from a C-semantics reference model through a scoreboard queue.
module tb_ptcalc_top_sdiv_u7;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               in_vld;
    logic               in_rdy;
    logic signed [28:0] din0;
    logic        [6:0]  din1;
    logic               out_vld;
    logic               out_rdy;
    logic signed [21:0] dout;
    logic signed [7:0]  rem;
    logic               div0;
    logic               ovf;

    typedef struct {
        logic signed [21:0] q;
        logic signed [7:0]  r;
        logic               d0;
        logic               ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ptcalc_top_sdiv_u7 dut (
        .ap_clk  (ap_clk),
        .ap_rst  (ap_rst),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .din0    (din0),
        .din1    (din1),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .dout    (dout),
        .rem     (rem),
        .div0    (div0),
        .ovf     (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input longint a, input longint b);
        exp_t   e;
        longint q;
        e.d0 = 1'b0;
        e.ov = 1'b0;
        e.r  = '0;
        if (b == 0) begin
            e.d0 = 1'b1;
            e.q  = (a < 0) ? -22'sd2097152 : 22'sd2097151;
        end else begin
            q   = a / b;
            e.r = 8'(a % b);
            if (q > 2097151) begin
                e.q  = 22'sd2097151;
                e.ov = 1'b1;
            end else if (q < -2097152) begin
                e.q  = -22'sd2097152;
                e.ov = 1'b1;
            end else begin
                e.q = 22'(q);
            end
        end
        return e;
    endfunction

    // Presents one operand pair, waits for acceptance, and scores the expected result.
    task automatic issue(input longint a, input longint b, input exp_t e);
        int n = 0;
        @(negedge ap_clk);
        din0   = 29'(a);
        din1   = 7'(b);
        in_vld = 1'b1;
        while (!in_rdy && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        check("accept_wait", 32'(in_rdy), 1);
        @(posedge ap_clk);
        sb.push_back(e);
        @(negedge ap_clk);
        in_vld = 1'b0;
        din0   = 29'sd777;
        din1   = 7'd3;
    endtask

    task automatic collect(input string tag, input int lat_exp, input int hold);
        int   n = 0;
        exp_t e;
        while (!out_vld && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        check({tag, "_vld"}, 32'(out_vld), 1);
        if (lat_exp >= 0)
            check({tag, "_lat"}, n, lat_exp);
        e = sb.pop_front();
        check({tag, "_dout"}, dout, e.q);
        check({tag, "_rem"},  rem,  e.r);
        check({tag, "_div0"}, 32'(div0), 32'(e.d0));
        check({tag, "_ovf"},  32'(ovf),  32'(e.ov));
        for (int i = 0; i < hold; i++) begin
            in_vld = 1'b1;
            din0   = 29'(i * 1000 - 3);
            din1   = 7'(i + 1);
            @(negedge ap_clk);
            check({tag, "_hold_vld"},  32'(out_vld), 1);
            check({tag, "_hold_rdy"},  32'(in_rdy), 0);
            check({tag, "_hold_dout"}, dout, e.q);
            check({tag, "_hold_rem"},  rem,  e.r);
            check({tag, "_hold_flags"}, 32'({div0, ovf}), 32'({e.d0, e.ov}));
        end
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        @(negedge ap_clk);
        out_rdy = 1'b0;
        if (lat_exp >= 0) begin
            check({tag, "_drop_vld"}, 32'(out_vld), 0);
            check({tag, "_back_rdy"}, 32'(in_rdy), 1);
        end
    endtask

    task automatic run_op(input string tag, input longint a, input longint b, input int lat_exp);
        issue(a, b, model(a, b));
        collect(tag, lat_exp, 0);
    endtask

    initial begin
        exp_t e;
        longint a;
        longint b;
        ap_rst  = 1'b1;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        din0    = '0;
        din1    = '0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        @(negedge ap_clk);

        check("rst_in_rdy", 32'(in_rdy), 1);
        check("rst_out_vld", 32'(out_vld), 0);
        check("rst_dout", dout, 0);
        check("rst_rem", rem, 0);
        check("rst_flags", 32'({div0, ovf}), 0);

        run_op("neg1000_7", -1000, 7, 30);
        run_op("12345_100", 12345, 100, 30);
        run_op("min28_127", -268435456, 127, 30);
        run_op("max28_127", 268435455, 127, 30);
        run_op("min28_1", -268435456, 1, 30);
        run_op("qmax_1", 2097151, 1, 30);
        run_op("qmin_1", -2097152, 1, 30);
        run_op("qmaxp1_1", 2097152, 1, 30);
        run_op("zero_5", 0, 5, 30);
        run_op("div0_pos", 100, 0, 1);
        run_op("div0_neg", -100, 0, 1);
        run_op("div0_zero", 0, 0, 1);

        // Result held in DONE while stray operands are offered.
        issue(-77777, 13, model(-77777, 13));
        collect("hold", 30, 5);
        run_op("after_hold", 999, 9, 30);

        // Reset during CALC discards the operation in flight.
        issue(5000, 3, model(5000, 3));
        repeat (9) @(negedge ap_clk);
        ap_rst = 1'b1;
        #1;
        check("abort_vld", 32'(out_vld), 0);
        check("abort_rdy", 32'(in_rdy), 1);
        void'(sb.pop_back());
        @(negedge ap_clk);
        ap_rst = 1'b0;
        repeat (40) @(negedge ap_clk);
        check("abort_stale_vld", 32'(out_vld), 0);
        run_op("35_5", 35, 5, 30);

        run_op("rt_min", -2097152 * 127, 127, 30);
        for (int k = 0; k < 1000; k++) begin
            a    = longint'($signed(22'($urandom)));
            b    = longint'($urandom_range(1, 127));
            e.q  = 22'(a);
            e.r  = '0;
            e.d0 = 1'b0;
            e.ov = 1'b0;
            issue(a * b, b, e);
            collect("roundtrip", -1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
